stall_scheduler: RTL and testbench

Shares the program-counter stall resource among several stall requesters (memory wait, multiply, debug, etc.) in the strawberry core. Each requester asks for a stall of a given number of clock cycles; the block grants one request at a time using round-robin arbitration. It counts the granted stall down and holds `pcEn` low for exactly that many cycles, replacing ad-hoc per-source delay logic with one sequenced controller.

---
 rtl/stall_pkg.sv | 6 +
 rtl/stall_scheduler_if.sv | 20 ++
 rtl/stall_scheduler_rr_arbiter.sv | 19 +
 rtl/stall_scheduler.sv | 80 ++++++++
 tb/tb_stall_scheduler.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/stall_pkg.sv
// stall_pkg: shared FSM state type and width constants for stall_scheduler.
package stall_pkg;
  typedef enum logic [1:0] {IDLE, STALL, DONE} state_e;
  localparam int CNT_W_DEF = 8;
  localparam int STATS_W = 32;
endpackage

// File: rtl/stall_scheduler_if.sv
// stall_scheduler_if: requester-side bundle; stall_total exists only with STALL_SCHED_STATS_EN.
interface stall_scheduler_if import stall_pkg::*; #(
  parameter int NREQ = 4,
  parameter int CNT_W = CNT_W_DEF
);
  logic [NREQ-1:0] req;
  logic [NREQ*CNT_W-1:0] req_cycles;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] done;
  logic pcEn;
  logic busy;
`ifdef STALL_SCHED_STATS_EN
  logic [STATS_W-1:0] stall_total;
  modport master(output req, req_cycles, input grant, done, pcEn, busy, stall_total);
  modport slave(input req, req_cycles, output grant, done, pcEn, busy, stall_total);
`else
  modport master(output req, req_cycles, input grant, done, pcEn, busy);
  modport slave(input req, req_cycles, output grant, done, pcEn, busy);
`endif
endinterface

// File: rtl/stall_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set bit upward from ptr_i with wrap.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] win_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);
  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % NREQ]) idx_o = IW'((int'(ptr_i) + k) % NREQ);
    win_o = any_o ? NREQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/stall_scheduler.sv
// stall_scheduler: round-robin shared PC-stall sequencer; define STALL_SCHED_STATS_EN for the
// saturating stall_total counter.
module stall_scheduler import stall_pkg::*; #(
  parameter int NREQ = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  stall_scheduler_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cycles_w;
  logic [IW-1:0] w_q, w_d, ptr_q, ptr_d, win_idx;
  logic [NREQ-1:0] grant_q, grant_d, done_q, done_d, win_oh;
  logic pc_en_q, busy_q, win_any;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i(bus.req), .ptr_i(ptr_q), .win_o(win_oh), .idx_o(win_idx), .any_o(win_any)
  );
  assign cycles_w = bus.req_cycles[int'(win_idx)*CNT_W +: CNT_W];
  // A zero-length grant enters DONE with done_q clear, so its done pulse lands one cycle later.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    w_d = w_q;
    ptr_d = ptr_q;
    grant_d = '0;
    done_d = '0;
    case (state_q)
      IDLE: if (win_any) begin
        cnt_d = cycles_w;
        w_d = win_idx;
        grant_d = win_oh;
        state_d = (cycles_w == '0) ? DONE : STALL;
      end
      STALL: begin
        cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q == CNT_W'(1)) ? DONE : STALL;
        done_d = (cnt_q == CNT_W'(1)) ? NREQ'(1) << w_q : '0;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d = (w_q == IW'(NREQ - 1)) ? '0 : w_q + 1'b1;
        done_d = (done_q == '0) ? NREQ'(1) << w_q : '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      w_q <= '0;
      ptr_q <= '0;
      grant_q <= '0;
      done_q <= '0;
      pc_en_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      w_q <= w_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      done_q <= done_d;
      pc_en_q <= state_d != STALL;
      busy_q <= state_d != IDLE;
    end
  assign bus.grant = grant_q;
  assign bus.done = done_q;
  assign bus.pcEn = pc_en_q;
  assign bus.busy = busy_q;
`ifdef STALL_SCHED_STATS_EN
  logic [STATS_W-1:0] stats_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) stats_q <= '0;
    else if (!pc_en_q && !(&stats_q)) stats_q <= stats_q + 1'b1;
  assign bus.stall_total = stats_q;
`endif
endmodule

// File: tb/tb_stall_scheduler.sv
// tb_stall_scheduler: directed checks of stall_scheduler (NREQ=4, CNT_W=8); stats checks
// compile in with STALL_SCHED_STATS_EN.
module tb_stall_scheduler;
  logic clk, rst;
  int pass_cnt = 0, total_cnt = 0, w;
  stall_scheduler_if #(.NREQ(4), .CNT_W(8)) bus ();
  stall_scheduler #(.NREQ(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", tag, got, exp);
  endtask
  task automatic serve(input string tag, input logic [3:0] exp, input int n, output int waits);
    int lows;
    waits = 0;
    @(negedge clk);
    while (bus.grant == '0 && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    chk({tag, " grant"}, bus.grant, exp);
    lows = 0;
    while (!bus.pcEn && lows < 300) begin
      lows++;
      @(negedge clk);
    end
    chk({tag, " low cycles"}, lows, n);
    chk({tag, " done"}, bus.done, exp);
  endtask
  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.req_cycles = '0;
    repeat (2) @(negedge clk);
    chk("rst pcEn", bus.pcEn, 1);
    chk("rst grant", bus.grant, 0);
    chk("rst done", bus.done, 0);
    chk("rst busy", bus.busy, 0);
    rst = 1'b0;
    // contention, pointer starts at 0
    bus.req = 4'b1111;
    bus.req_cycles = {8'd3, 8'd3, 8'd3, 8'd3};
    serve("c0", 4'b0001, 3, w);
    serve("c1", 4'b0010, 3, w);
    chk("c1 gap", w + 1, 2);
    serve("c2", 4'b0100, 3, w);
    chk("c2 gap", w + 1, 2);
    serve("c3", 4'b1000, 3, w);
    chk("c3 gap", w + 1, 2);
    serve("c4", 4'b0001, 3, w);
    chk("c4 gap", w + 1, 2);
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk("c idle busy", bus.busy, 0);
    // single request, length changed after grant must be ignored
    bus.req = 4'b0010;
    bus.req_cycles = {8'd0, 8'd0, 8'd5, 8'd0};
    @(negedge clk);
    chk("s grant", bus.grant, 4'b0010);
    chk("s pcEn first", bus.pcEn, 0);
    chk("s busy", bus.busy, 1);
    bus.req = '0;
    bus.req_cycles = {8'd0, 8'd0, 8'd2, 8'd0};
    @(negedge clk);
    chk("s grant one cycle", bus.grant, 0);
    for (int i = 0; i < 4; i++) begin
      chk("s pcEn low", bus.pcEn, 0);
      @(negedge clk);
    end
    chk("s pcEn back", bus.pcEn, 1);
    chk("s done", bus.done, 4'b0010);
    chk("s busy in done", bus.busy, 1);
    @(negedge clk);
    chk("s done cleared", bus.done, 0);
    chk("s busy fall", bus.busy, 0);
    // zero length
    bus.req = 4'b0100;
    bus.req_cycles = '0;
    @(negedge clk);
    chk("z grant", bus.grant, 4'b0100);
    chk("z done early", bus.done, 0);
    chk("z pcEn", bus.pcEn, 1);
    bus.req = '0;
    @(negedge clk);
    chk("z grant cleared", bus.grant, 0);
    chk("z done", bus.done, 4'b0100);
    chk("z pcEn after", bus.pcEn, 1);
    @(negedge clk);
    chk("z done cleared", bus.done, 0);
    // pointer is now 3
    bus.req = 4'b1001;
    bus.req_cycles = {8'd2, 8'd0, 8'd0, 8'd2};
    serve("f3", 4'b1000, 2, w);
    serve("f0", 4'b0001, 2, w);
    bus.req = '0;
    repeat (2) @(negedge clk);
    // reset mid-stall
    bus.req = 4'b0001;
    bus.req_cycles = {8'd0, 8'd0, 8'd0, 8'd10};
    @(negedge clk);
    chk("r grant", bus.grant, 4'b0001);
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk("r pcEn stall4", bus.pcEn, 0);
    #2 rst = 1'b1;
    #1;
    chk("r async pcEn", bus.pcEn, 1);
    chk("r async busy", bus.busy, 0);
    @(negedge clk);
    chk("r no done", bus.done, 0);
    rst = 1'b0;
    bus.req = 4'b0001;
    bus.req_cycles = {8'd0, 8'd0, 8'd0, 8'd2};
    serve("r0", 4'b0001, 2, w);
    bus.req = '0;
    @(negedge clk);
`ifdef STALL_SCHED_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("st reset", bus.stall_total, 0);
    bus.req = 4'b0010;
    bus.req_cycles = {8'd0, 8'd3, 8'd5, 8'd0};
    serve("st5", 4'b0010, 5, w);
    bus.req = 4'b0100;
    serve("st3", 4'b0100, 3, w);
    bus.req = '0;
    @(negedge clk);
    chk("st total", bus.stall_total, 8);
    force dut.stats_q = 32'hFFFF_FFFD;
    #1 release dut.stats_q;
    bus.req = 4'b1000;
    bus.req_cycles = {8'd5, 8'd0, 8'd0, 8'd0};
    serve("st sat", 4'b1000, 5, w);
    bus.req = '0;
    @(negedge clk);
    chk("st saturate", bus.stall_total, 32'hFFFF_FFFF);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
